// File: rtl/ir_car_pkg.sv
// ir_car_pkg
// Protocol constants and encodings shared by the IR car transmitter and
// receiver. It holds the nominal burst sizes (in carrier pulses), the nominal
// gap length (in carrier periods), the clock-to-carrier ratio, the receiver
// FSM state encoding and the burst classification used by the receiver.
package ir_car_pkg;

  localparam int CAR_CLOCK_RATIO       = 1250; // 50 MHz / 40 kHz
  localparam int CAR_START_BURST       = 88;
  localparam int CAR_SELECT_BURST      = 22;
  localparam int CAR_ASSERT_BURST      = 44;
  localparam int CAR_DEASSERT_BURST    = 22;
  localparam int CAR_GAP_SIZE          = 40;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SEL = 2'd1,
    ST_BITS     = 2'd2,
    ST_DONE     = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    BURST_GLITCH = 2'd0,
    BURST_SHORT  = 2'd1,
    BURST_LONG   = 2'd2,
    BURST_START  = 2'd3
  } burst_class_e;

  // Thresholds sit halfway between neighbouring nominal burst sizes so that
  // a burst that lost or gained a few pulses still lands in the right class.
  function automatic burst_class_e classify_burst(
    input logic [7:0] count,
    input int         start_sz,
    input int         assert_sz,
    input int         deassert_sz
  );
    if (int'(count) >= (start_sz + assert_sz) / 2) begin
      return BURST_START;
    end else if (int'(count) >= (assert_sz + deassert_sz) / 2) begin
      return BURST_LONG;
    end else if (int'(count) >= deassert_sz / 2) begin
      return BURST_SHORT;
    end else begin
      return BURST_GLITCH;
    end
  endfunction

endpackage

// File: rtl/ir_burst_meter.sv
// ir_burst_meter
// Synchronizes the raw IR detector input, counts carrier pulses inside a
// burst and measures the silence since the last carrier rising edge.
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_ir         raw IR detector input (asynchronous)
//   o_burst_end  one-cycle pulse when a burst has ended
//   o_count      pulse count of the burst that just ended (valid with o_burst_end)
//   o_silence    cycles since the last carrier rising edge (saturating)
module ir_burst_meter
  import ir_car_pkg::*;
#(
  parameter int ClockRatio = CAR_CLOCK_RATIO,
  parameter bit RxInvert   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ir,
  output logic        o_burst_end,
  output logic [7:0]  o_count,
  output logic [18:0] o_silence
);

  // Registered burst end is raised one cycle early so that it is high
  // exactly while the silence timer reads 2*ClockRatio-1.
  localparam logic [18:0] LP_END_EARLY = 19'(2 * ClockRatio - 2);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [7:0]  r_pulses;
  logic [18:0] r_timer;
  logic        r_burst_end;
  logic [7:0]  r_count;

  logic        w_rx;
  logic        w_rise;
  logic        w_end_next;

  assign w_rx       = r_sync2 ^ RxInvert;
  assign w_rise     = w_rx & ~r_prev;
  assign w_end_next = (r_timer == LP_END_EARLY) && !w_rise && (r_pulses != 8'd0);

  // r_prev resets high so that an input already active at reset release is
  // not counted as a carrier edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_ir;
      r_sync2 <= r_sync1;
      r_prev  <= w_rx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pulses <= 8'd0;
    end else if (w_rise) begin
      if (r_pulses != 8'hFF) begin
        r_pulses <= r_pulses + 8'd1;
      end
    end else if (w_end_next) begin
      r_pulses <= 8'd0;
    end
  end

  // Timer resets to its saturated value so no timeout or burst end can fire
  // before the first carrier edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '1;
    end else if (w_rise) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + 19'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_burst_end <= 1'b0;
      r_count     <= 8'd0;
    end else begin
      r_burst_end <= w_end_next;
      if (w_end_next) begin
        r_count <= r_pulses;
      end
    end
  end

  assign o_burst_end = r_burst_end;
  assign o_count     = r_count;
  assign o_silence   = r_timer;

endmodule

// File: rtl/ir_receiver_sm.sv
// ir_receiver_sm
// IR car command receiver. Bursts of carrier pulses are measured by
// ir_burst_meter and classified by length; a packet is START, CAR_SELECT and
// four direction bits (long burst = 1, short burst = 0), separated by gaps.
// Ports:
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset
//   IR_IN    raw carrier-modulated IR detector input (asynchronous)
//   COMMAND  last decoded command: [0]=RIGHT [1]=LEFT [2]=BACK [3]=FORWARD
//   VALID    one-cycle pulse when COMMAND is updated
//   ERROR    one-cycle pulse when a packet is aborted
module ir_receiver_sm
  import ir_car_pkg::*;
#(
  parameter int ClockRatio         = CAR_CLOCK_RATIO,
  parameter int StartBurstSize     = CAR_START_BURST,
  parameter int CarSelectBurstSize = CAR_SELECT_BURST,
  parameter int AsserBurstSize     = CAR_ASSERT_BURST,
  parameter int DeAsserBurstSize   = CAR_DEASSERT_BURST,
  parameter int GapSize            = CAR_GAP_SIZE,
  parameter bit RxInvert           = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       VALID,
  output logic       ERROR
);

  // A gap twice the nominal length means the transmitter went away.
  localparam logic [18:0] LP_GAP_TIMEOUT = 19'(2 * GapSize * ClockRatio);
  // Class that a nominal CAR_SELECT burst falls into (SHORT for the
  // standard burst sizes); the other data class in WAIT_SEL is an error.
  localparam burst_class_e LP_SEL_CLASS =
    classify_burst(8'(CarSelectBurstSize), StartBurstSize, AsserBurstSize, DeAsserBurstSize);

  logic         w_burst_end;
  logic [7:0]   w_count;
  logic [18:0]  w_silence;
  burst_class_e w_class;
  logic         w_timeout;

  rx_state_e    r_state,   w_state_nxt;
  logic [1:0]   r_index,   w_index_nxt;
  logic [3:0]   r_shift,   w_shift_nxt;
  logic [3:0]   r_command, w_command_nxt;
  logic         r_valid,   w_valid_nxt;
  logic         r_error,   w_error_nxt;

  ir_burst_meter #(
    .ClockRatio (ClockRatio),
    .RxInvert   (RxInvert)
  ) u_meter (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_ir        (IR_IN),
    .o_burst_end (w_burst_end),
    .o_count     (w_count),
    .o_silence   (w_silence)
  );

  assign w_class   = classify_burst(w_count, StartBurstSize, AsserBurstSize, DeAsserBurstSize);
  assign w_timeout = (w_silence == LP_GAP_TIMEOUT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_index   <= 2'd0;
      r_shift   <= 4'd0;
      r_command <= 4'd0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_index   <= w_index_nxt;
      r_shift   <= w_shift_nxt;
      r_command <= w_command_nxt;
      r_valid   <= w_valid_nxt;
      r_error   <= w_error_nxt;
    end
  end

  // VALID and COMMAND are registered on the transition into DONE, so they
  // are visible during the DONE cycle, one cycle after the final burst end.
  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_shift_nxt   = r_shift;
    w_command_nxt = r_command;
    w_valid_nxt   = 1'b0;
    w_error_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_burst_end && (w_class == BURST_START)) begin
          w_state_nxt = ST_WAIT_SEL;
          w_index_nxt = 2'd0;
        end
      end

      ST_WAIT_SEL: begin
        if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_burst_end) begin
          if (w_class == BURST_START) begin
            w_error_nxt = 1'b1;
            w_index_nxt = 2'd0;
          end else if (w_class == LP_SEL_CLASS) begin
            w_state_nxt = ST_BITS;
            w_index_nxt = 2'd0;
          end else if (w_class != BURST_GLITCH) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_BITS: begin
        if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_burst_end) begin
          if (w_class == BURST_START) begin
            w_error_nxt = 1'b1;
            w_index_nxt = 2'd0;
            w_state_nxt = ST_WAIT_SEL;
          end else if (w_class != BURST_GLITCH) begin
            w_shift_nxt[r_index] = (w_class == BURST_LONG);
            if (r_index == 2'd3) begin
              w_state_nxt   = ST_DONE;
              w_command_nxt = w_shift_nxt;
              w_valid_nxt   = 1'b1;
            end else begin
              w_index_nxt = r_index + 2'd1;
            end
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign COMMAND = r_command;
  assign VALID   = r_valid;
  assign ERROR   = r_error;

endmodule

// File: doc/ir_receiver_sm.md
IR_RECEIVER_SM -- requirements
Module: ir_receiver_sm

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ClockRatio, 1250, CLK cycles per carrier period (50 MHz / 40 kHz).
- StartBurstSize, 88, carrier pulses in START burst.
- CarSelectBurstSize, 22, pulses in CAR_SELECT burst.
- AsserBurstSize, 44, pulses for an asserted direction bit.
- DeAsserBurstSize, 22, pulses for a deasserted direction bit.
- GapSize, 40, nominal gap length in carrier periods.
- RxInvert, 0, 1 = IR_IN is active-low.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1, single system clock, rising edge.
- RST_N, in, 1, asynchronous active-low reset.
- IR_IN, in, 1, raw carrier-modulated IR detector input, asynchronous to CLK.
- COMMAND, out, 4, last decoded command: [0]=RIGHT, [1]=LEFT, [2]=BACK, [3]=FORWARD.
- VALID, out, 1, one-cycle pulse when COMMAND is updated.
- ERROR, out, 1, one-cycle pulse when a packet is aborted.

Function
REQ-003 IR_IN SHALL pass through a 2-flop synchronizer, then be XORed with RxInvert.
REQ-004 Each synchronized 0->1 transition SHALL increment an 8-bit pulse counter, saturating at 255.
REQ-005 A 19-bit silence timer SHALL clear on every rising edge and otherwise increment, saturating at its maximum.
REQ-006 When the silence timer equals 2*ClockRatio-1 with a nonzero pulse count, burst_end SHALL pulse for one cycle, and the pulse count SHALL be latched then cleared.
REQ-007 Burst class SHALL be derived from latched count N:
- START if N >= (StartBurstSize+AsserBurstSize)/2 (66).
- LONG if N >= (AsserBurstSize+DeAsserBurstSize)/2 (33).
- SHORT if N >= DeAsserBurstSize/2 (11).
- GLITCH otherwise.
REQ-008 FSM states SHALL be IDLE, WAIT_SEL, BITS and DONE.
REQ-009 IDLE: START -> WAIT_SEL; every other class is ignored.
REQ-010 WAIT_SEL: SHORT -> BITS with the bit index cleared; LONG -> ERROR pulse, then IDLE.
REQ-011 BITS: SHORT stores 0 and LONG stores 1 into shift[index], then index increments; after index 3 is stored -> DONE.
REQ-012 DONE: COMMAND SHALL load the 4 stored bits and VALID SHALL pulse in the same cycle (one cycle after the final burst_end); next state IDLE.
REQ-013 A GLITCH burst SHALL be ignored in every state, with no state or index change.
REQ-014 A START burst in WAIT_SEL or BITS SHALL pulse ERROR, clear the index and go to WAIT_SEL (resync).
REQ-015 If the silence timer reaches 2*GapSize*ClockRatio (100000) while in WAIT_SEL or BITS, the FSM SHALL pulse ERROR and go to IDLE.
REQ-016 COMMAND SHALL hold its value except on VALID; ERROR SHALL never alter COMMAND.
REQ-017 Latency: VALID SHALL occur 2*ClockRatio+1 cycles after the last rising edge of the FORWARD burst.
REQ-018 VALID and ERROR SHALL never be high in the same cycle.

Reset
REQ-019 RST_N low SHALL asynchronously clear: synchronizer flops, pulse counter, silence timer (to saturated value), FSM (IDLE), index, shift bits, COMMAND=0, VALID=0, ERROR=0.
REQ-020 Reset mid-packet SHALL discard partial data; the first full packet after release SHALL decode normally.

Structure
REQ-021 Package ir_car_pkg SHALL hold the FSM state encodings and the protocol constant defaults (burst sizes, GapSize, ClockRatio), shared with the transmitter.
REQ-022 Sub-module ir_burst_meter SHALL contain the synchronizer, pulse counter and silence timer, and output burst_end, the latched count and the silence timer value.
REQ-023 Target size is 150-300 lines of RTL in total.

Verification
REQ-024 Full packet (START 88, gaps 40, SEL 22, bits 44/22/44/22) -> COMMAND=4'b0101, a single VALID pulse, no ERROR.
REQ-025 Packet with all bits 22 pulses -> COMMAND=4'b0000 with VALID; a following 44/44/44/44 packet -> COMMAND=4'b1111.
REQ-026 Gap after SEL stretched to 90 periods -> ERROR pulse at silence 100000, no VALID, COMMAND unchanged.
REQ-027 5-pulse burst inserted between bits 1 and 2 -> ignored; COMMAND matches the transmitted bits.
REQ-028 New START after 2 bits, followed by a complete packet 1,0,0,1 -> one ERROR pulse, then VALID with COMMAND=4'b1001.
REQ-029 RST_N low mid-bit -> outputs clear immediately; the next packet decodes correctly.
